// File: rtl/inst_fetcher_pkg.sv
// Shared widths, queue depth default, fetch FSM encoding and queue entry layout
// for the instruction fetcher and its queue.
package inst_fetcher_pkg;

    localparam int INS_LEN      = 32;
    localparam int ADDR_LEN     = 32;
    localparam int IQ_DEPTH_DEF = 4;

    localparam logic [ADDR_LEN-1:0] INST_BYTES = ADDR_LEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DROP  = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [INS_LEN-1:0]  inst;
        logic [ADDR_LEN-1:0] pc;
    } iq_entry_t;

    // Sequential fetch address; wraps silently at 2^32.
    function automatic logic [ADDR_LEN-1:0] next_pc(input logic [ADDR_LEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue: head entry visible combinationally, push/pop same
// cycle allowed (including pop on full), flush empties it in one edge.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  iq_entry_t i_push_dat,
    input  logic      i_pop,
    input  logic      i_flush,
    output iq_entry_t o_head_dat,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == CNT_FULL);
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_head];

    // A pop frees the slot the same edge, so a push into a full queue is legal then.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_push_dat;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory read at a time, results queued
// for the decoder; jump_flag flushes the queue and redirects the fetch pc.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                  IQ_DEPTH = IQ_DEPTH_DEF,
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic                mem_done,
    input  logic [INS_LEN-1:0]  mem_inst,
    input  logic                jump_flag,
    input  logic [ADDR_LEN-1:0] jump_pc,
    output logic                out_valid,
    output logic [INS_LEN-1:0]  out_inst,
    output logic [ADDR_LEN-1:0] out_pc,
    input  logic                issue_ready
);

    fetch_state_t        r_state;
    logic [ADDR_LEN-1:0] r_pc;
    logic                r_mem_req;
    logic [ADDR_LEN-1:0] r_mem_addr;

    logic      w_push;
    logic      w_pop;
    logic      w_flush;
    logic      w_full;
    logic      w_empty;
    iq_entry_t w_push_dat;
    iq_entry_t w_head_dat;

    // Redirect outranks everything: no push, no pop, queue emptied.
    assign w_flush    = rdy & jump_flag;
    assign w_push     = rdy & ~jump_flag & mem_done & (r_state == ST_FETCH);
    assign w_pop      = rdy & ~jump_flag & issue_ready & ~w_empty;
    assign w_push_dat = '{inst: mem_inst, pc: r_pc};

    inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (jump_flag) begin
                        r_pc <= jump_pc;
                    end else if (!w_full) begin
                        r_state    <= ST_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end
                end
                ST_FETCH: begin
                    if (jump_flag) begin
                        // A word returning on the redirect edge is simply dropped.
                        r_pc      <= jump_pc;
                        r_mem_req <= 1'b0;
                        r_state   <= mem_done ? ST_IDLE : ST_DROP;
                    end else if (mem_done) begin
                        r_pc      <= next_pc(r_pc);
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (jump_flag) begin
                        r_pc <= jump_pc;
                    end
                    // The stale reply must be absorbed before a new request can go out.
                    if (mem_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign out_valid = ~w_empty;
    assign out_inst  = w_head_dat.inst;
    assign out_pc    = w_head_dat.pc;

endmodule
